spi_mnrch_arbiter: RTL and testbench

//   Shares one SPI_mnrch between NUM_REQ requesters (inertial interface, A2D/battery monitor, ...).

---
 rtl/spi_arb_pkg.sv | 22 ++
 rtl/spi_rr_pick.sv | 25 ++
 rtl/spi_mnrch_arbiter.sv | 129 ++++++++++++
 tb/tb_spi_mnrch_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI monarch arbiter: FSM state encoding and command width.
// Also holds a one-hot to index helper that supports up to four requesters.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int CMD_W = 16;
  localparam int IDX_W = 2;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [3:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) oh2idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: returns the first requester set after index last_i.
// The request vector is rotated, its lowest set bit is isolated, and the result is rotated back.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  logic [2:0]         shAmt;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rotLow;

  // Rotation puts index (last+1) mod NUM_REQ at bit 0, so the lowest set bit is the winner.
  assign shAmt  = {1'b0, last_i} + 3'd1;
  assign rot    = NUM_REQ'({req_i, req_i} >> shAmt);
  assign rotLow = rot & (~rot + NUM_REQ'(1));
  assign gnt_o  = NUM_REQ'(({rotLow, rotLow} << shAmt) >> NUM_REQ);
  assign any_o  = |req_i;

endmodule

// File: rtl/spi_mnrch_arbiter.sv
// Round-robin arbiter sharing one SPI monarch between NUM_REQ requesters.
// Define SPI_TMO_EN to enable the BUSY timeout (err_o pulses after TMO_CYCLES without mnrch_done).
module spi_mnrch_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int TMO_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CMD_W*NUM_REQ-1:0] cmd_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [CMD_W-1:0]         rd_data_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic                     wrt,
  output logic [CMD_W-1:0]         wt_data,
  input  logic                     mnrch_done,
  input  logic [CMD_W-1:0]         mnrch_rd,
  input  logic                     mnrch_SS_n,
  output logic [NUM_REQ-1:0]       SS_n_o
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TMO_CYCLES < 1 || TMO_CYCLES > 65536) begin : g_param_check
    $error("spi_mnrch_arbiter: unsupported NUM_REQ or TMO_CYCLES");
  end

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               wrt_q;
  logic [CMD_W-1:0]   rdData_q;
  logic [IDX_W-1:0]   last_q;
  logic [NUM_REQ-1:0] pickGnt;
  logic               pickAny;
  logic [CMD_W-1:0]   wtData;

  spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pickGnt),
    .any_o  (pickAny)
  );

`ifdef SPI_TMO_EN
  logic [NUM_REQ-1:0] err_q;
  logic [15:0]        tmoCnt_q;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      wrt_q    <= 1'b0;
      rdData_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
`ifdef SPI_TMO_EN
      err_q    <= '0;
      tmoCnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pickAny) begin
            gnt_q   <= pickGnt;
            wrt_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wrt_q   <= 1'b0;
          state_q <= BUSY;
`ifdef SPI_TMO_EN
          tmoCnt_q <= '0;
`endif
        end
        // A completion in the same cycle as the timeout takes priority.
        BUSY: begin
          if (mnrch_done) begin
            rdData_q <= mnrch_rd;
            done_q   <= gnt_q;
            state_q  <= RELEASE;
          end
`ifdef SPI_TMO_EN
          else if (tmoCnt_q == TMO_LAST) begin
            err_q   <= gnt_q;
            state_q <= RELEASE;
          end else begin
            tmoCnt_q <= tmoCnt_q + 16'd1;
          end
`endif
        end
        RELEASE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          last_q  <= oh2idx(4'(gnt_q));
          state_q <= IDLE;
`ifdef SPI_TMO_EN
          err_q   <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wtData = '0;
    if (state_q != IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_q[i]) wtData = cmd_in[CMD_W*i +: CMD_W];
      end
    end
  end

  assign gnt       = gnt_q;
  assign done_o    = done_q;
  assign wrt       = wrt_q;
  assign rd_data_o = rdData_q;
  assign wt_data   = wtData;
  assign SS_n_o    = ~gnt_q | {NUM_REQ{mnrch_SS_n}};

endmodule

// File: tb/tb_spi_mnrch_arbiter.sv
// Scoreboard bench for spi_mnrch_arbiter with a behavioural SPI monarch model.
// Define SPI_TMO_EN to also exercise the BUSY timeout path with TMO_CYCLES=64.
module tb_spi_mnrch_arbiter;

  localparam int NREQ = 2;
`ifdef SPI_TMO_EN
  localparam int TB_TMO = 64;
`else
  localparam int TB_TMO = 4096;
`endif

  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] cmd;
  } wExp_t;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] rd;
  } dExp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] cmdIn = '0;
  logic [1:0]  gnt, done_o, err_o, SS_n_o;
  logic [15:0] rd_data_o, wt_data;
  logic        wrt;
  logic        mnrch_done;
  logic [15:0] mnrch_rd;
  logic        mnrch_SS_n;

  logic        modelDone;
  logic        strayDone = 1'b0;
  logic        modelEn = 1'b1;
  int          modelLat = 5;
  logic        modelBusy;
  int          modelCnt;

  wExp_t       expW[$];
  dExp_t       expD[$];
  logic [15:0] rspQ[$];

  int          passCnt = 0;
  int          totalCnt = 0;

  assign mnrch_done = modelDone | strayDone;

  always #5 clk = ~clk;

  spi_mnrch_arbiter #(.NUM_REQ(NREQ), .TMO_CYCLES(TB_TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .cmd_in     (cmdIn),
    .gnt        (gnt),
    .done_o     (done_o),
    .rd_data_o  (rd_data_o),
    .err_o      (err_o),
    .wrt        (wrt),
    .wt_data    (wt_data),
    .mnrch_done (mnrch_done),
    .mnrch_rd   (mnrch_rd),
    .mnrch_SS_n (mnrch_SS_n),
    .SS_n_o     (SS_n_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Monarch model: starts on wrt, holds SS_n low, answers with the next queued response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelBusy  <= 1'b0;
      modelCnt   <= 0;
      modelDone  <= 1'b0;
      mnrch_rd   <= '0;
      mnrch_SS_n <= 1'b1;
    end else begin
      modelDone <= 1'b0;
      if (modelBusy) begin
        if (modelCnt == 0) begin
          modelDone  <= 1'b1;
          modelBusy  <= 1'b0;
          mnrch_SS_n <= 1'b1;
        end else begin
          modelCnt <= modelCnt - 1;
        end
      end else if (wrt && modelEn) begin
        modelBusy  <= 1'b1;
        modelCnt   <= modelLat;
        mnrch_SS_n <= 1'b0;
        mnrch_rd   <= (rspQ.size() > 0) ? rspQ.pop_front() : 16'hDEAD;
      end
    end
  end

  // Monitor: compares every wrt and every done/err pulse against the scoreboard queues.
  int   cyc = 0;
  bit   active = 0;
  int   actIdx = 0;
  int   wrtCyc = 0;
  int   lastDoneCyc = 0;
  bit   haveDone = 0;
  logic prevWrt = 1'b0;

  always @(negedge clk) begin
    wExp_t      w;
    dExp_t      d;
    logic [1:0] expSs;
    if (!rst_n) begin
      expW.delete();
      expD.delete();
      active   = 0;
      haveDone = 0;
      prevWrt  = 1'b0;
    end else begin
      cyc++;
      if (wrt) begin
        checkOutput("wrtSinglePulse", 32'(prevWrt), 32'd0);
        if (haveDone) checkOutput("wrtGapAfterDone", 32'(cyc - lastDoneCyc >= 2), 32'd1);
        if (expW.size() == 0) begin
          checkOutput("unexpectedWrt", 32'(wrt), 32'd0);
        end else begin
          w = expW.pop_front();
          checkOutput("gnt", 32'(gnt), 32'(w.gnt));
          checkOutput("wtData", 32'(wt_data), 32'(w.cmd));
          actIdx = w.gnt[1] ? 1 : 0;
          active = 1;
          wrtCyc = cyc;
        end
      end else if (!active) begin
        checkOutput("idleGnt", 32'(gnt), 32'd0);
        checkOutput("idleSsN", 32'(SS_n_o), 32'h3);
        checkOutput("idleWtData", 32'(wt_data), 32'd0);
      end
      if (active) begin
        expSs = 2'b11;
        expSs[actIdx] = mnrch_SS_n;
        checkOutput("ssnSteer", 32'(SS_n_o), 32'(expSs));
        checkOutput("gntHeld", 32'(gnt), 32'(2'b01 << actIdx));
      end
      if (|done_o || |err_o) begin
        if (expD.size() == 0) begin
          checkOutput("unexpectedDone", 32'({done_o, err_o}), 32'd0);
        end else begin
          d = expD.pop_front();
          checkOutput("doneVec", 32'(done_o), 32'(d.done));
          checkOutput("errVec", 32'(err_o), 32'(d.err));
          checkOutput("rdData", 32'(rd_data_o), 32'(d.rd));
          if (d.err != 2'b00) checkOutput("tmoLatency", 32'(cyc - wrtCyc), 32'd65);
        end
        active      = 0;
        haveDone    = 1;
        lastDoneCyc = cyc;
      end
      prevWrt = wrt;
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] c0, input logic [15:0] c1);
    cmdIn = {c1, c0};
    req   = r;
  endtask

  task automatic expectTxn(input int idx, input logic [15:0] cmd, input logic [15:0] rd);
    wExp_t w;
    dExp_t d;
    w.gnt  = 2'(2'b01 << idx);
    w.cmd  = cmd;
    d.done = w.gnt;
    d.err  = 2'b00;
    d.rd   = rd;
    expW.push_back(w);
    expD.push_back(d);
    rspQ.push_back(rd);
  endtask

  task automatic waitDones(input int n, input int budget);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (|done_o || |err_o) seen++;
    end
    if (seen < n) checkOutput("waitDonesExpired", 32'(seen), 32'(n));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rspQ.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c;
    bit saw;
    dExp_t d;
    wExp_t w;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstGnt", 32'(gnt), 32'd0);
    checkOutput("rstWrt", 32'(wrt), 32'd0);
    checkOutput("rstDone", 32'(done_o), 32'd0);
    checkOutput("rstErr", 32'(err_o), 32'd0);
    checkOutput("rstRdData", 32'(rd_data_o), 32'd0);
    checkOutput("rstSsN", 32'(SS_n_o), 32'h3);

    // Single requester 0, long monarch latency
    $display("[TB] single request");
    modelLat = 31;
    expectTxn(0, 16'hA600, 16'h00C5);
    applyStimulus(2'b01, 16'hA600, 16'h0000);
    waitDones(1, 200);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Simultaneous requests from reset: 0 then 1
    $display("[TB] simultaneous requests");
    doReset();
    modelLat = 5;
    expectTxn(0, 16'h0D02, 16'h0111);
    expectTxn(1, 16'hA700, 16'h0222);
    applyStimulus(2'b11, 16'h0D02, 16'hA700);
    waitDones(1, 200);
    req = 2'b10;
    waitDones(1, 200);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Both held for six transactions: strict alternation
    $display("[TB] round-robin fairness");
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) expectTxn(0, 16'h5A01, 16'(16'h1000 + k));
      else            expectTxn(1, 16'h5A02, 16'(16'h1000 + k));
    end
    applyStimulus(2'b11, 16'h5A01, 16'h5A02);
    waitDones(6, 400);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Grant to requester 1 (select steering checked by monitor), then stray done in IDLE
    $display("[TB] select steering and stray done");
    expectTxn(1, 16'hB00B, 16'h4BB4);
    applyStimulus(2'b10, 16'h0000, 16'hB00B);
    waitDones(1, 200);
    req = 2'b00;
    repeat (3) @(negedge clk);
    strayDone = 1'b1;
    @(negedge clk);
    strayDone = 1'b0;
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      if (|done_o) saw = 1;
    end
    checkOutput("strayDoneIgnored", 32'(saw), 32'd0);
    checkOutput("rdDataHeld", 32'(rd_data_o), 32'h4BB4);

`ifdef SPI_TMO_EN
    // Monarch never answers: timeout pulse, no done, rd_data_o unchanged
    $display("[TB] timeout");
    modelEn = 1'b0;
    w.gnt  = 2'b01;
    w.cmd  = 16'h7777;
    d.done = 2'b00;
    d.err  = 2'b01;
    d.rd   = 16'h4BB4;
    expW.push_back(w);
    expD.push_back(d);
    applyStimulus(2'b01, 16'h7777, 16'h0000);
    waitDones(1, 200);
    req = 2'b00;
    modelEn = 1'b1;
    repeat (3) @(negedge clk);
`endif

    // Reset in the middle of BUSY
    $display("[TB] reset mid-transaction");
    modelLat = 20;
    expectTxn(0, 16'h1234, 16'h5678);
    applyStimulus(2'b01, 16'h1234, 16'h0000);
    c = 0;
    while (!wrt && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput("wrtBeforeReset", 32'(wrt), 32'd1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstGnt", 32'(gnt), 32'd0);
    checkOutput("asyncRstWrt", 32'(wrt), 32'd0);
    checkOutput("asyncRstSsN", 32'(SS_n_o), 32'h3);
    checkOutput("asyncRstDone", 32'(done_o), 32'd0);
    req = 2'b00;
    @(negedge clk);
    rspQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    modelLat = 5;
    expectTxn(0, 16'hC3C3, 16'h3C3C);
    applyStimulus(2'b01, 16'hC3C3, 16'h0000);
    waitDones(1, 200);
    req = 2'b00;
    repeat (4) @(negedge clk);

    checkOutput("scoreboardDrainW", 32'(expW.size()), 32'd0);
    checkOutput("scoreboardDrainD", 32'(expD.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
